filter_row_engine: RTL

- Streaming PNG scanline filter engine; generalises the single-byte Paeth predictor to all five PNG filter types (None/Sub/Up/Average/Paeth) over BPP byte lanes per pixel.
- Holds the previous scanline in an internal line buffer and keeps the left pixel and upper-left pixel in registers.
- Emits one filter-type byte per row, followed by the filtered pixels.
- Sits between the pixel unpacker and the deflate compressor.

---
 rtl/filter_row_engine_pkg.sv | 23 ++
 rtl/filter_row_engine_if.sv | 33 +++
 rtl/filter_row_engine_pred_lane.sv | 53 +++++
 rtl/filter_row_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_row_engine_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | filter_pkg: filter type codes, FSM encodings, SAD width helper   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package filter_pkg;

  localparam logic [2:0] FLT_NONE  = 3'd0;
  localparam logic [2:0] FLT_SUB   = 3'd1;
  localparam logic [2:0] FLT_UP    = 3'd2;
  localparam logic [2:0] FLT_AVG   = 3'd3;
  localparam logic [2:0] FLT_PAETH = 3'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  function automatic int sad_width(input int data_wd, input int width_wd, input int bpp);
    return data_wd + width_wd + $clog2(bpp) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/filter_row_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | filter_row_engine_if: config, pixel input and filtered output bus |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface filter_row_engine_if #(
  parameter int DATA_WD  = 8,
  parameter int BPP      = 4,
  parameter int WIDTH_WD = 10
);
  logic                     frame_start_i;
  logic [WIDTH_WD-1:0]      cfg_width_i;
  logic [2:0]               cfg_type_i;
  logic                     in_vld_i;
  logic                     in_rdy_o;
  logic [BPP*DATA_WD-1:0]   in_dat_i;
  logic                     out_vld_o;
  logic                     out_rdy_i;
  logic [BPP*DATA_WD-1:0]   out_dat_o;
  logic                     out_typ_o;
  logic                     out_eor_o;

  modport master (
    output frame_start_i, cfg_width_i, cfg_type_i, in_vld_i, in_dat_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_dat_o, out_typ_o, out_eor_o
  );

  modport slave (
    input  frame_start_i, cfg_width_i, cfg_type_i, in_vld_i, in_dat_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_dat_o, out_typ_o, out_eor_o
  );
endinterface
`default_nettype wire

// File: rtl/filter_row_engine_pred_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | filter_pred_lane: combinational PNG predictor for one byte lane  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module filter_pred_lane
  import filter_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic [DATA_WD-1:0] a_i,
  input  logic [DATA_WD-1:0] b_i,
  input  logic [DATA_WD-1:0] c_i,
  input  logic [2:0]         type_i,
  output logic [DATA_WD-1:0] pred_o
);

  logic [DATA_WD:0]          w_sum;
  logic signed [DATA_WD+1:0] w_bc, w_ac, w_abc;
  logic signed [DATA_WD+1:0] w_pa, w_pb, w_pc;
  logic [DATA_WD-1:0]        w_paeth;

  always_comb begin
    w_sum = {1'b0, a_i} + {1'b0, b_i};
    // pa=|b-c|, pb=|a-c|, pc=|a+b-2c| are the distances of p=a+b-c from a, b, c
    w_bc  = $signed({2'b00, b_i}) - $signed({2'b00, c_i});
    w_ac  = $signed({2'b00, a_i}) - $signed({2'b00, c_i});
    w_abc = w_bc + w_ac;
    w_pa  = (w_bc  < 0) ? -w_bc  : w_bc;
    w_pb  = (w_ac  < 0) ? -w_ac  : w_ac;
    w_pc  = (w_abc < 0) ? -w_abc : w_abc;
    if (w_pa <= w_pb && w_pa <= w_pc) begin
      w_paeth = a_i;
    end else if (w_pb <= w_pc) begin
      w_paeth = b_i;
    end else begin
      w_paeth = c_i;
    end
  end

  always_comb begin
    pred_o = '0;
    case (type_i)
      FLT_SUB:   pred_o = a_i;
      FLT_UP:    pred_o = b_i;
      FLT_AVG:   pred_o = DATA_WD'(w_sum >> 1);
      FLT_PAETH: pred_o = w_paeth;
      default:   pred_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/filter_row_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | filter_row_engine: streaming PNG row filter, type beat + pixels; |
// | FILTER_SAD_EN adds row SAD output. Rev 1.0                       |
// +------------------------------------------------------------------+
module filter_row_engine
  import filter_pkg::*;
#(
  parameter int DATA_WD   = 8,
  parameter int BPP       = 4,
  parameter int WIDTH_MAX = 1024,
  parameter int WIDTH_WD  = 10
) (
  input  logic               clk,
  input  logic               rst,
  filter_row_engine_if.slave bus
`ifdef FILTER_SAD_EN
  ,
  output logic [sad_width(DATA_WD, WIDTH_WD, BPP)-1:0] row_sad_o,
  output logic                                         row_sad_vld_o
`endif
);

  localparam int LW = BPP * DATA_WD;

  logic [1:0]          state_q, state_d;
  logic [WIDTH_WD-1:0] col_q, col_d;
  logic [WIDTH_WD-1:0] width_q, width_d;
  logic [2:0]          type_q, type_d;
  logic                first_row_q, first_row_d;
  logic [LW-1:0]       left_q, left_d;
  logic [LW-1:0]       upleft_q, upleft_d;
  logic                out_vld_q, out_vld_d;
  logic [LW-1:0]       out_dat_q, out_dat_d;
  logic                out_typ_q, out_typ_d;
  logic                out_eor_q, out_eor_d;

  logic [LW-1:0]       lbuf_q [WIDTH_MAX];

  logic                w_load, w_last, w_in_rdy, w_fire, w_head_ld, w_cfg_ld;
  logic [2:0]          w_cfg_type;
  logic [LW-1:0]       w_upper, w_pred, w_resid;

  assign w_load     = !out_vld_q || bus.out_rdy_i;
  assign w_last     = (col_q == width_q);
  assign w_cfg_type = (bus.cfg_type_i > FLT_PAETH) ? FLT_NONE : bus.cfg_type_i;
  assign w_upper    = first_row_q ? '0 : lbuf_q[col_q];

  genvar l;
  generate
    for (l = 0; l < BPP; l++) begin : g_lane
      filter_pred_lane #(.DATA_WD(DATA_WD)) u_pred (
        .a_i    (left_q[l*DATA_WD +: DATA_WD]),
        .b_i    (w_upper[l*DATA_WD +: DATA_WD]),
        .c_i    (upleft_q[l*DATA_WD +: DATA_WD]),
        .type_i (type_q),
        .pred_o (w_pred[l*DATA_WD +: DATA_WD])
      );
      assign w_resid[l*DATA_WD +: DATA_WD] =
        bus.in_dat_i[l*DATA_WD +: DATA_WD] - w_pred[l*DATA_WD +: DATA_WD];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.frame_start_i || bus.in_vld_i) state_d = HEAD;
      HEAD: if (!bus.frame_start_i && w_load) state_d = DATA;
      DATA: begin
        if (w_fire && w_last) begin
          state_d = IDLE;
        end else if (bus.frame_start_i) begin
          state_d = HEAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame start mid-row blocks input so the row is abandoned; on the last column it may complete
  always_comb begin
    w_in_rdy  = (state_q == DATA) && w_load && (!bus.frame_start_i || w_last);
    w_fire    = bus.in_vld_i && w_in_rdy;
    w_head_ld = (state_q == HEAD) && !bus.frame_start_i && w_load;
    w_cfg_ld  = (state_d == HEAD) && ((state_q != HEAD) || bus.frame_start_i);
  end

  always_comb begin
    width_d     = width_q;
    type_d      = type_q;
    col_d       = col_q;
    first_row_d = first_row_q;
    left_d      = left_q;
    upleft_d    = upleft_q;
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_typ_d   = out_typ_q;
    out_eor_d   = out_eor_q;

    if (w_cfg_ld) begin
      width_d = bus.cfg_width_i;
      type_d  = w_cfg_type;
    end

    if (bus.frame_start_i) begin
      first_row_d = 1'b1;
    end else if (w_fire && w_last) begin
      first_row_d = 1'b0;
    end

    if (w_head_ld) begin
      col_d    = '0;
      left_d   = '0;
      upleft_d = '0;
    end else if (w_fire) begin
      col_d    = w_last ? '0 : col_q + 1'b1;
      left_d   = bus.in_dat_i;
      upleft_d = w_upper;
    end

    if (w_load) begin
      out_vld_d = w_head_ld || w_fire;
      if (w_head_ld) begin
        out_dat_d      = '0;
        out_dat_d[2:0] = type_q;
        out_typ_d      = 1'b1;
        out_eor_d      = 1'b0;
      end else if (w_fire) begin
        out_dat_d = w_resid;
        out_typ_d = 1'b0;
        out_eor_d = w_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q     <= '0;
      type_q      <= FLT_NONE;
      col_q       <= '0;
      first_row_q <= 1'b1;
      left_q      <= '0;
      upleft_q    <= '0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_typ_q   <= 1'b0;
      out_eor_q   <= 1'b0;
    end else begin
      width_q     <= width_d;
      type_q      <= type_d;
      col_q       <= col_d;
      first_row_q <= first_row_d;
      left_q      <= left_d;
      upleft_q    <= upleft_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_typ_q   <= out_typ_d;
      out_eor_q   <= out_eor_d;
    end
  end

  // Registered write, combinational read: a same-address read sees the upper row
  always_ff @(posedge clk) begin
    if (w_fire) begin
      lbuf_q[col_q] <= bus.in_dat_i;
    end
  end

  assign bus.in_rdy_o  = w_in_rdy;
  assign bus.out_vld_o = out_vld_q;
  assign bus.out_dat_o = out_dat_q;
  assign bus.out_typ_o = out_typ_q;
  assign bus.out_eor_o = out_eor_q;

`ifdef FILTER_SAD_EN
  localparam int SAD_WD = sad_width(DATA_WD, WIDTH_WD, BPP);

  logic [SAD_WD-1:0]  sad_q, sad_d;
  logic               sad_pend_q, sad_vld_q;
  logic [DATA_WD:0]   w_mag;

  // |r| of a two's-complement lane is 2^DATA_WD - r when r is negative
  always_comb begin
    sad_d = sad_q;
    w_mag = '0;
    if (w_head_ld) begin
      sad_d = '0;
    end else if (w_fire) begin
      for (int i = 0; i < BPP; i++) begin
        w_mag = w_resid[i*DATA_WD + DATA_WD - 1]
              ? (({1'b1, {DATA_WD{1'b0}}}) - {1'b0, w_resid[i*DATA_WD +: DATA_WD]})
              : {1'b0, w_resid[i*DATA_WD +: DATA_WD]};
        sad_d = sad_d + SAD_WD'(w_mag);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sad_q      <= '0;
      sad_pend_q <= 1'b0;
      sad_vld_q  <= 1'b0;
    end else begin
      sad_q      <= sad_d;
      sad_pend_q <= w_fire && w_last && w_load;
      sad_vld_q  <= sad_pend_q;
    end
  end

  assign row_sad_o     = sad_q;
  assign row_sad_vld_o = sad_vld_q;
`endif

endmodule
`default_nettype wire
